// File: rtl/nvdla_cdp_mul_arb.sv
// Round-robin arbiter sharing one registered signed multiplier among NREQ requesters.
// Optional build macro NVDLA_CDP_MUL_ARB_PERF_EN adds a saturating request-stall counter.
module nvdla_cdp_mul_arb #(
  parameter int NREQ   = 4,
  parameter int INA_BW = 9,
  parameter int INB_BW = 16,
  parameter int TAG_BW = 2
) (
  input  logic                       nvdla_core_clk,
  input  logic                       nvdla_core_rst,
  input  logic [NREQ-1:0]            req_vld,
  output logic [NREQ-1:0]            req_rdy,
  input  logic [NREQ*INA_BW-1:0]     req_ina_pd,
  input  logic [NREQ*INB_BW-1:0]     req_inb_pd,
  output logic [NREQ-1:0]            res_vld,
  input  logic [NREQ-1:0]            res_rdy,
  output logic [INA_BW+INB_BW-1:0]   res_pd,
  output logic [TAG_BW-1:0]          res_tag,
  output logic                       arb_idle
`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
  ,
  output logic [31:0]                perf_stall_cnt
`endif
);

  localparam int PD_BW = INA_BW + INB_BW;

  logic [TAG_BW-1:0]        rr_ptr_q;
  logic [TAG_BW-1:0]        rr_ptr_d;
  logic [TAG_BW-1:0]        win_s;
  logic [TAG_BW-1:0]        idx_s;
  logic                     found_s;
  logic                     out_vld_s;
  logic                     pipe_rdy_s;
  logic                     accept_s;
  logic signed [INA_BW-1:0] ina_s;
  logic signed [INB_BW-1:0] inb_s;
  logic signed [PD_BW-1:0]  prod_s;
  logic [NREQ-1:0]          win_oh_s;
  logic [NREQ-1:0]          res_vld_q;
  logic [NREQ-1:0]          res_vld_d;
  logic [PD_BW-1:0]         res_pd_q;
  logic [PD_BW-1:0]         res_pd_d;
  logic [TAG_BW-1:0]        res_tag_q;
  logic [TAG_BW-1:0]        res_tag_d;

  // Winner is the first valid requester at or after rr_ptr, wrapping modulo NREQ.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx_s = TAG_BW'((int'(rr_ptr_q) + k) % NREQ);
      if (!found_s && req_vld[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign ina_s      = req_ina_pd[int'(win_s)*INA_BW +: INA_BW];
  assign inb_s      = req_inb_pd[int'(win_s)*INB_BW +: INB_BW];
  assign prod_s     = PD_BW'(inb_s) * PD_BW'(ina_s);
  assign win_oh_s   = {{(NREQ-1){1'b0}}, 1'b1} << win_s;

  // Only the owner's res_rdy can free the single output slot.
  assign out_vld_s  = |res_vld_q;
  assign pipe_rdy_s = ~out_vld_s | res_rdy[res_tag_q];
  assign accept_s   = found_s & pipe_rdy_s;
  assign req_rdy    = accept_s ? win_oh_s : {NREQ{1'b0}};
  assign arb_idle   = ~out_vld_s & ~(|req_vld);

  // Output slot: load on accept, clear on drain, otherwise hold.
  always_comb begin
    res_vld_d = res_vld_q;
    res_pd_d  = res_pd_q;
    res_tag_d = res_tag_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept_s) begin
      res_vld_d = win_oh_s;
      res_pd_d  = prod_s;
      res_tag_d = win_s;
      rr_ptr_d  = TAG_BW'((int'(win_s) + 1) % NREQ);
    end else if (out_vld_s && res_rdy[res_tag_q]) begin
      res_vld_d = {NREQ{1'b0}};
    end else begin
      res_vld_d = res_vld_q;
    end
  end

  // State registers.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      res_vld_q <= {NREQ{1'b0}};
      res_pd_q  <= {PD_BW{1'b0}};
      res_tag_q <= {TAG_BW{1'b0}};
      rr_ptr_q  <= {TAG_BW{1'b0}};
    end else begin
      res_vld_q <= res_vld_d;
      res_pd_q  <= res_pd_d;
      res_tag_q <= res_tag_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  assign res_vld = res_vld_q;
  assign res_pd  = res_pd_q;
  assign res_tag = res_tag_q;

`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_d;

  // Count cycles with pending requests but no accept; saturate instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req_vld) && !accept_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      stall_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`else
`endif

endmodule

// File: tb/tb_nvdla_cdp_mul_arb.sv
// Self-checking bench for nvdla_cdp_mul_arb: vector table, scoreboard monitor, corner sequences.
module tb_nvdla_cdp_mul_arb;

  localparam int NREQ   = 4;
  localparam int INA_BW = 9;
  localparam int INB_BW = 16;
  localparam int TAG_BW = 2;
  localparam int PD_BW  = 25;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NREQ-1:0]          req_vld = '0;
  logic [NREQ-1:0]          req_rdy;
  logic [NREQ*INA_BW-1:0]   req_ina_pd = '0;
  logic [NREQ*INB_BW-1:0]   req_inb_pd = '0;
  logic [NREQ-1:0]          res_vld;
  logic [NREQ-1:0]          res_rdy = 4'b1111;
  logic [PD_BW-1:0]         res_pd;
  logic [TAG_BW-1:0]        res_tag;
  logic                     arb_idle;
`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
  logic [31:0]              perf_stall_cnt;
`endif

  nvdla_cdp_mul_arb #(
    .NREQ(NREQ), .INA_BW(INA_BW), .INB_BW(INB_BW), .TAG_BW(TAG_BW)
  ) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_ina_pd     (req_ina_pd),
    .req_inb_pd     (req_inb_pd),
    .res_vld        (res_vld),
    .res_rdy        (res_rdy),
    .res_pd         (res_pd),
    .res_tag        (res_tag),
    .arb_idle       (arb_idle)
`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_ina_pd[i*INA_BW +: INA_BW] = 9'(a);
    req_inb_pd[i*INB_BW +: INB_BW] = 16'(b);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    req_vld = '0;
    res_rdy = 4'b1111;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  function automatic logic [PD_BW-1:0] ref_prod(input int i);
    int a;
    int b;
    a = int'($signed(req_ina_pd[i*INA_BW +: INA_BW]));
    b = int'($signed(req_inb_pd[i*INB_BW +: INB_BW]));
    return PD_BW'(a * b);
  endfunction

  // Scoreboard monitor: reference arbiter predicts grants, queue holds expected results.
  typedef struct {
    logic [TAG_BW-1:0] tag;
    logic [PD_BW-1:0]  pd;
  } sb_t;
  sb_t             sb[$];
  sb_t             sb_e;
  logic [1:0]      m_ptr;
  logic [1:0]      m_win;
  logic            m_vld;
  logic            m_found;
  logic            m_pipe;
  logic [NREQ-1:0] m_rdy;
  bit              mon_en = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_ptr = 2'd0;
      m_vld = 1'b0;
      sb.delete();
    end else if (mon_en) begin
      m_pipe = 1'b1;
      if (m_vld) begin
        chk("sb_vld", 64'(res_vld), 64'(4'b0001 << sb[0].tag));
        chk("sb_tag", 64'(res_tag), 64'(sb[0].tag));
        chk("sb_pd", {39'd0, res_pd}, {39'd0, sb[0].pd});
        m_pipe = res_rdy[sb[0].tag];
      end else begin
        chk("sb_novld", 64'(res_vld), 64'(0));
      end
      m_found = 1'b0;
      m_win   = 2'd0;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (int'(m_ptr) + k) % NREQ;
        if (!m_found && req_vld[j]) begin
          m_found = 1'b1;
          m_win   = 2'(j);
        end
      end
      m_rdy = (m_found && m_pipe) ? (4'b0001 << m_win) : 4'b0000;
      chk("req_rdy", 64'(req_rdy), 64'(m_rdy));
      chk("arb_idle", 64'(arb_idle), 64'(!m_vld && (req_vld == 4'b0000)));
      if (m_vld && m_pipe) begin
        void'(sb.pop_front());
        m_vld = 1'b0;
      end
      if (m_found && m_pipe) begin
        sb_e.tag = m_win;
        sb_e.pd  = ref_prod(int'(m_win));
        sb.push_back(sb_e);
        m_vld = 1'b1;
        m_ptr = 2'((int'(m_win) + 1) % NREQ);
      end
    end
  end

  typedef struct {
    int req;
    int ina;
    int inb;
    int exp_pd;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{2,   -3,   1000,    -3000};
    vecs[1] = '{0, -256, -32768,  8388608};
    vecs[2] = '{3,  255, -32768, -8355840};
    vecs[3] = '{1,  255,  32767,  8355585};
    vecs[4] = '{2, -256,  32767, -8388352};
    vecs[5] = '{1,    0,  -1234,        0};
    vecs[6] = '{3,   -1,     -1,        1};

    cyc();
    cyc();
    rst    = 1'b0;
    mon_en = 1'b1;
    chk("rst_vld", 64'(res_vld), 64'(0));
    chk("rst_pd", {39'd0, res_pd}, 64'(0));
    chk("rst_tag", 64'(res_tag), 64'(0));
    chk("rst_idle", 64'(arb_idle), 64'(1));
`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
    chk("rst_perf", 64'(perf_stall_cnt), 64'(0));
`endif

    // Single-requester products, including the operand extremes.
    foreach (vecs[n]) begin
      int t;
      set_op(vecs[n].req, vecs[n].ina, vecs[n].inb);
      req_vld = 4'b0001 << vecs[n].req;
      t = 0;
      while (((req_vld & req_rdy) == 4'b0000) && (t < 10)) begin
        cyc();
        t++;
      end
      chk("vec_grant", 64'(t < 10), 64'(1));
      cyc();
      req_vld = '0;
      chk("vec_vld", 64'(res_vld), 64'(4'b0001 << vecs[n].req));
      chk("vec_tag", 64'(res_tag), 64'(vecs[n].req));
      chk("vec_pd", {39'd0, res_pd}, {39'd0, 25'(vecs[n].exp_pd)});
    end
    cyc();

    // All requesters active: strict rotation, one result per cycle.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, i * 7 - 10, 300 * i - 500);
    req_vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      cyc();
      chk("rr_tag", 64'(res_tag), 64'(k % 4));
      chk("rr_vld", 64'(res_vld), 64'(4'b0001 << (k % 4)));
    end
    req_vld = '0;
    cyc();

    // Owner backpressure holds the slot, blocks grants, then rotation resumes.
    do_reset();
    set_op(1, 100, -200);
    set_op(2, 3, 4);
    set_op(3, -5, 6);
    res_rdy = 4'b1101;
    req_vld = 4'b0010;
    cyc();
    req_vld = 4'b1100;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_tag", 64'(res_tag), 64'(1));
      chk("bp_vld", 64'(res_vld), 64'(4'b0010));
      chk("bp_pd", {39'd0, res_pd}, {39'd0, 25'(-20000)});
      chk("bp_rdy", 64'(req_rdy), 64'(0));
    end
`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
    chk("perf_stall", 64'(perf_stall_cnt), 64'(5));
`endif
    res_rdy = 4'b1111;
    cyc();
    chk("bp_resume2", 64'(res_tag), 64'(2));
    req_vld = 4'b1000;
    cyc();
    chk("bp_resume3", 64'(res_tag), 64'(3));
    chk("bp_pd3", {39'd0, res_pd}, {39'd0, 25'(-30)});
    req_vld = '0;
    cyc();
    chk("bp_drain", 64'(res_vld), 64'(0));

    // Reset with a result held discards it and returns rr_ptr to 0.
    do_reset();
    res_rdy = 4'b0000;
    set_op(2, 5, 6);
    req_vld = 4'b0100;
    cyc();
    chk("hold_vld", 64'(res_vld), 64'(4'b0100));
    req_vld = '0;
    cyc();
    rst = 1'b1;
    #1;
    chk("mid_rst_vld", 64'(res_vld), 64'(0));
    chk("mid_rst_idle", 64'(arb_idle), 64'(1));
    cyc();
    rst     = 1'b0;
    res_rdy = 4'b1111;
`ifdef NVDLA_CDP_MUL_ARB_PERF_EN
    chk("mid_rst_perf", 64'(perf_stall_cnt), 64'(0));
`endif
    set_op(1, -7, 9);
    set_op(3, 11, 13);
    req_vld = 4'b1010;
    cyc();
    chk("post_rst_tag", 64'(res_tag), 64'(1));
    chk("post_rst_pd", {39'd0, res_pd}, {39'd0, 25'(-63)});
    req_vld = 4'b1000;
    cyc();
    chk("post_rst_tag3", 64'(res_tag), 64'(3));
    req_vld = '0;
    cyc();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
